divider_unit: RTL
=================

# divider_unit

Sequential unsigned restoring divider, the inverse of the team's 8-bit shift-add multiplier datapath. It uses a left-shifting remainder/quotient register pair, where the multiplier uses right-shifting accumulator/operand registers. It retires one quotient bit per clock and sits beside the multiplier under the same push-button Run control and switch/LED-style operand I/O. A divide-by-zero is detected up front and flagged instead of being computed.

## Interface
- N, default 8: operand width. Quotient and remainder are also N bits; the iteration count is N.
- Clk  in  1: single system clock; all state changes on the rising edge.
- Reset  in  1: synchronous, active-high. Returns the block to IDLE and clears all outputs.
- Run  in  1: start request, level-sensitive. Starts an operation when sampled high in IDLE. Must return low before another operation can start.
- Dividend  in  N: unsigned dividend, sampled only on the start edge.
- Divisor  in  N: unsigned divisor, sampled only on the start edge.
- Quotient  out  N: quotient register (shares storage with the shifted dividend).
- Remainder  out  N: partial or final remainder register.
- Busy  out  1: high while in CALC.
- Done  out  1: high in HOLD, meaning the result is valid.
- DivZero  out  1: high in HOLD when the captured divisor was 0; otherwise 0.

## Operation
- State machine: IDLE, CALC, HOLD.
- IDLE, Run=1 and Divisor≠0:
  - Q ← Dividend, R ← 0, D ← Divisor, cnt ← 0.
  - Next state CALC.
- IDLE, Run=1 and Divisor=0:
  - Q ← all ones, R ← Dividend, DivZero ← 1.
  - Next state HOLD. No CALC cycles.
- IDLE, Run=0: hold all registers. Q and R keep the last result.
- CALC step, one per cycle:
  - S = {R, Q[N-1]}, N+1 bits.
  - If S ≥ {0, D}: R ← (S − D)[N-1:0] and Q ← {Q[N-2:0], 1}.
  - Else: R ← S[N-1:0] and Q ← {Q[N-2:0], 0}.
  - cnt ← cnt+1.
  - On the step where cnt = N−1, go to HOLD.
- Width rule: R < D always holds, so S < 2D and every restored or subtracted value fits in N bits.
- HOLD:
  - Done=1. Q and R are frozen.
  - Stay in HOLD while Run=1.
  - Run=0 moves to IDLE. DivZero clears on leaving HOLD; Q and R are retained.
- Run changes during CALC are ignored. Dividend and Divisor changes after the start edge have no effect.
- Reset has priority in every state:
  - Next edge: IDLE, Q=0, R=0, D=0, cnt=0, Busy=Done=DivZero=0.
  - A reset mid-CALC aborts the operation with no partial result kept.

## Timing
- Reset values: Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0, state IDLE.
- E0 is the edge that samples Run=1 in IDLE.
  - Normal case: CALC steps occur at E1..EN. Done=1 and Busy=0 are visible after EN, which is 8 cycles after E0 for N=8.
  - Busy=1 after E0 through EN.
- Divide-by-zero: Done=1 and DivZero=1 are visible after E0 (1-cycle latency). Busy never asserts.
- Intermediate Q and R values are observable during CALC but carry no meaning until Done.
- Run held high through HOLD does not retrigger. A new start needs at least one IDLE cycle with Run=0, then Run=1.
- The earliest possible restart is edge EN+2:
  - Run goes low after EN, so HOLD→IDLE happens at EN+1.
  - Run goes high again, so it is sampled at EN+2.
- Reset asserted in the same cycle as Run in IDLE: reset wins and no operation starts.

## Test plan
- Reset, then Dividend=200, Divisor=7, Run pulse → Busy for 8 cycles; after E8: Quotient=28 (0x1C), Remainder=4, Done=1, DivZero=0.
- 255/1 → Quotient=255, Remainder=0. Then 5/9 after releasing Run → Quotient=0, Remainder=5. Each Done exactly 8 cycles after its start edge.
- Dividend=0x5A, Divisor=0, Run → after E0: Done=1, DivZero=1, Quotient=0xFF, Remainder=0x5A, Busy never high. Run low → IDLE with DivZero=0.
- Start 200/7, assert Reset after E4 for one cycle → next edge: all outputs 0, state IDLE. Done stays 0 even with Run still high, until Run is released and re-pressed.
- Hold Run high for 30 cycles on 100/10 → exactly one operation (Quotient=10, Remainder=0), Done stays 1. Change Dividend to 255 during CALC → result unchanged.
- Release Run, then start 255/255 → Quotient=1, Remainder=0. Then 254/255 → Quotient=0, Remainder=254, which checks the S ≥ D boundary.

Source files
------------

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// The dividend is shifted left out of Q into R while quotient bits shift into Q from the right.
// A zero divisor skips the iteration and goes directly to HOLD with DivZero set.
module divider_unit #(
    parameter int unsigned N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           divzero_q, divzero_d;
    // Set once Run has been seen low; a start consumes it, so Run left high
    // (after HOLD or across a reset) never retriggers.
    logic           armed_q, armed_d;

    logic [N:0]     s;
    logic           ge;
    logic [N-1:0]   diff;

    // Trial subtraction for one restoring step
    always_comb begin
        s    = {r_q, q_q[N-1]};
        ge   = (s >= {1'b0, d_q});
        // R < D keeps S - D below 2^N, so the low N bits are the whole result
        diff = s[N-1:0] - d_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        r_d       = r_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        divzero_d = divzero_q;
        armed_d   = armed_q;

        if (!Run) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (Run && armed_q) begin
                    armed_d = 1'b0;
                    if (Divisor != '0) begin
                        q_d     = Dividend;
                        r_d     = '0;
                        d_d     = Divisor;
                        cnt_d   = '0;
                        state_d = StCalc;
                    end else begin
                        q_d       = '1;
                        r_d       = Dividend;
                        divzero_d = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StCalc: begin
                if (ge) begin
                    r_d = diff;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = s[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!Run) begin
                    divzero_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            q_q       <= '0;
            r_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            r_q       <= r_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            divzero_q <= divzero_d;
            armed_q   <= armed_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        Quotient  = q_q;
        Remainder = r_q;
        Busy      = (state_q == StCalc);
        Done      = (state_q == StHold);
        DivZero   = divzero_q;
    end

endmodule
